// File: rtl/imm_encoder_if.sv
// Handshake and data bundle for imm_encoder.
// slave = encoder side, master = loader/driver side.
interface imm_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ImmSrc;
  logic [31:0]       Imm;
  logic [31:0]       Base;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       Instr;
  logic [ADDR_W-1:0] WAddr;
  logic              ErrPulse;
  logic [CNT_W-1:0]  ErrCount;

  modport slave (
    input  in_valid, ImmSrc, Imm, Base, out_ready,
    output in_ready, out_valid, Instr, WAddr,
    output ErrPulse, ErrCount
  );

  modport master (
    output in_valid, ImmSrc, Imm, Base, out_ready,
    input  in_ready, out_valid, Instr, WAddr,
    input  ErrPulse, ErrCount
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a signed immediate into I/S/B/J instruction fields.
// Ports: clk, reset (async active-low), bus (imm_encoder_if.slave).
module imm_encoder #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              CNT_W     = 16
) (
  input logic            clk,
  input logic            reset,
  imm_encoder_if.slave   bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_err_pulse;
  logic [CNT_W-1:0]  r_err_cnt;

  logic        w_out_valid;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_xfer;
  logic        w_legal;
  logic [31:0] w_enc;
  logic [31:0] w_imm;
  logic [31:0] w_base;

  assign w_imm       = bus.Imm;
  assign w_base      = bus.Base;
  assign w_out_valid = (r_state == S_FULL);
  assign w_in_ready  = !w_out_valid || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_xfer      = w_out_valid && bus.out_ready;

  // A value fits in N signed bits when all bits
  // from N-1 upward agree with the sign bit.
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;

  assign w_fit12 = (&w_imm[31:11]) || !(|w_imm[31:11]);
  assign w_fit13 = (&w_imm[31:12]) || !(|w_imm[31:12]);
  assign w_fit21 = (&w_imm[31:20]) || !(|w_imm[31:20]);

  always_comb begin
    w_legal = 1'b0;
    unique case (bus.ImmSrc)
      2'b00: w_legal = w_fit12;
      2'b01: w_legal = w_fit12;
      2'b10: w_legal = w_fit13 && !w_imm[0];
      2'b11: w_legal = w_fit21 && !w_imm[0];
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_enc = w_base;
    unique case (bus.ImmSrc)
      2'b00: w_enc = {w_imm[11:0], w_base[19:0]};
      2'b01: w_enc = {w_imm[11:5], w_base[24:12],
                      w_imm[4:0], w_base[6:0]};
      2'b10: w_enc = {w_imm[12], w_imm[10:5],
                      w_base[24:12], w_imm[4:1],
                      w_imm[11], w_base[6:0]};
      2'b11: w_enc = {w_imm[20], w_imm[10:1],
                      w_imm[11], w_imm[19:12],
                      w_base[11:0]};
      default: w_enc = w_base;
    endcase
  end

  // WAddr advances on every transfer, so a word
  // loaded in the same cycle picks up the new address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_instr     <= '0;
      r_waddr     <= BASE_ADDR;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      if (w_xfer) begin
        r_waddr <= r_waddr + ADDR_W'(4);
      end
      if (w_accept && w_legal) begin
        r_state <= S_FULL;
        r_instr <= w_enc;
      end else if (w_xfer) begin
        r_state <= S_EMPTY;
      end
      if (w_accept && !w_legal &&
          (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.Instr     = r_instr;
  assign bus.WAddr     = r_waddr;
  assign bus.ErrPulse  = r_err_pulse;
  assign bus.ErrCount  = r_err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder.
// Drives after posedge, samples on negedge.
module tb_imm_encoder;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;

  imm_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  imm_encoder #(
    .ADDR_W(32),
    .BASE_ADDR(32'h0),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send(logic [1:0] src,
                      logic [31:0] imm,
                      logic [31:0] base);
    bus.in_valid = 1'b1;
    bus.ImmSrc   = src;
    bus.Imm      = imm;
    bus.Base     = base;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ImmSrc    = 2'b00;
    bus.Imm       = '0;
    bus.Base      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_instr", bus.Instr, 0);
    check("rst_waddr", bus.WAddr, 0);
    check("rst_errp", 32'(bus.ErrPulse), 0);
    check("rst_errc", 32'(bus.ErrCount), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 1);

    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0013);
    check("i_valid", 32'(bus.out_valid), 1);
    check("i_instr", bus.Instr, 32'hFFF0_0013);
    check("i_waddr", bus.WAddr, 32'd0);
    send(2'b01, 32'd8, 32'h0000_2023);
    check("s_instr", bus.Instr, 32'h0000_2423);
    check("s_waddr", bus.WAddr, 32'd4);
    send(2'b10, 32'hFFFF_FFFC, 32'h0000_0063);
    check("b_instr", bus.Instr, 32'hFE00_0EE3);
    check("b_waddr", bus.WAddr, 32'd8);
    send(2'b11, 32'h0000_0800, 32'h0000_006F);
    check("j_instr", bus.Instr, 32'h0010_006F);
    check("j_waddr", bus.WAddr, 32'd12);
    @(negedge clk);
    check("drain_valid", 32'(bus.out_valid), 0);
    check("drain_waddr", bus.WAddr, 32'd16);

    send(2'b00, 32'd2048, 32'h0000_0013);
    check("e1_valid", 32'(bus.out_valid), 0);
    check("e1_pulse", 32'(bus.ErrPulse), 1);
    check("e1_count", 32'(bus.ErrCount), 1);
    send(2'b10, 32'd3, 32'h0000_0063);
    check("e2_valid", 32'(bus.out_valid), 0);
    check("e2_pulse", 32'(bus.ErrPulse), 1);
    check("e2_count", 32'(bus.ErrCount), 2);
    check("e2_waddr", bus.WAddr, 32'd16);
    @(negedge clk);
    check("e_pulse_lo", 32'(bus.ErrPulse), 0);

    send(2'b00, 32'd2047, 32'h0000_0013);
    check("imax_instr", bus.Instr, 32'h7FF0_0013);
    check("imax_waddr", bus.WAddr, 32'd16);
    send(2'b00, 32'hFFFF_F800, 32'h0000_0013);
    check("imin_instr", bus.Instr, 32'h8000_0013);
    check("imin_waddr", bus.WAddr, 32'd20);
    send(2'b10, 32'd4094, 32'h0000_0063);
    check("bmax_instr", bus.Instr, 32'h7E00_0FE3);
    send(2'b11, 32'hFFF0_0000, 32'h0000_006F);
    check("jmin_instr", bus.Instr, 32'h8000_006F);
    check("jmin_waddr", bus.WAddr, 32'd28);
    send(2'b11, 32'h0010_0000, 32'h0000_006F);
    check("e3_valid", 32'(bus.out_valid), 0);
    check("e3_count", 32'(bus.ErrCount), 3);
    check("e3_waddr", bus.WAddr, 32'd32);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.ImmSrc    = 2'b00;
    bus.Base      = 32'h0000_0013;
    bus.Imm       = 32'd1;
    @(posedge clk);
    #1;
    bus.Imm = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("st_ready", 32'(bus.in_ready), 0);
      check("st_instr", bus.Instr, 32'h0010_0013);
      check("st_waddr", bus.WAddr, 32'd32);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rel_valid", 32'(bus.out_valid), 1);
    check("rel_instr", bus.Instr, 32'h0020_0013);
    check("rel_waddr", bus.WAddr, 32'd36);
    @(negedge clk);
    check("rel_drain", 32'(bus.out_valid), 0);
    check("rel_waddr2", bus.WAddr, 32'd40);

    bus.out_ready = 1'b0;
    send(2'b00, 32'd3, 32'h0000_0013);
    check("r_pre_valid", 32'(bus.out_valid), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(bus.out_valid), 0);
    check("ar_count", 32'(bus.ErrCount), 0);
    check("ar_waddr", bus.WAddr, 32'd0);
    check("ar_instr", bus.Instr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_valid", 32'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
